// File: rtl/mac_scheduler_pkg.sv
// Shared types, requester product slices and tag sizing for the MAC scheduler.
package mac_scheduler_pkg;
  localparam int NUM_REQ_DEF   = 5;

  // Product bit ranges each requester family keeps from the 32-bit result
  localparam int ENV_SLICE_HI  = 23;
  localparam int ENV_SLICE_LO  = 8;
  localparam int VOL_SLICE_HI  = 19;
  localparam int VOL_SLICE_LO  = 4;
  localparam int FILT_SLICE_HI = 31;
  localparam int FILT_SLICE_LO = 16;

  typedef logic [15:0] opnd_t;
  typedef logic [31:0] prod_t;

  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mac_scheduler_core.sv
// Two-stage multiply pipe: issue regs -> signed16 x unsigned16 multiply -> result regs.
module mac_core
  import mac_scheduler_pkg::*;
#(
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_v_i,
  input  opnd_t           a_i,
  input  opnd_t           b_i,
  input  logic [ID_W-1:0] tag_i,
  output logic            s0_v_o,
  output logic            res_v_o,
  output logic [ID_W-1:0] res_tag_o,
  output prod_t           res_o
);
  logic            s0_v_q, s1_v_q;
  opnd_t           a_q, b_q;
  logic [ID_W-1:0] tag0_q, tag1_q;
  prod_t           prod_q, mult;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_v_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      tag0_q <= '0;
    end else begin
      s0_v_q <= issue_v_i;
      if (issue_v_i) begin
        a_q    <= a_i;
        b_q    <= b_i;
        tag0_q <= tag_i;
      end
    end
  end

`ifdef ICE40_MAC
  SB_MAC16 #(
    .A_SIGNED(1'b1), .B_SIGNED(1'b0),
    .TOPOUTPUT_SELECT(2'b11), .BOTOUTPUT_SELECT(2'b11),
    .A_REG(1'b0), .B_REG(1'b0), .C_REG(1'b0), .D_REG(1'b0),
    .TOP_8x8_MULT_REG(1'b0), .BOT_8x8_MULT_REG(1'b0),
    .PIPELINE_16x16_MULT_REG1(1'b0), .PIPELINE_16x16_MULT_REG2(1'b0)
  ) u_mac (
    .CLK(clk), .CE(1'b1), .A(a_q), .B(b_q), .C(16'h0), .D(16'h0),
    .AHOLD(1'b0), .BHOLD(1'b0), .CHOLD(1'b0), .DHOLD(1'b0),
    .IRSTTOP(1'b0), .IRSTBOT(1'b0), .ORSTTOP(1'b0), .ORSTBOT(1'b0),
    .OLOADTOP(1'b0), .OLOADBOT(1'b0), .ADDSUBTOP(1'b0), .ADDSUBBOT(1'b0),
    .OHOLDTOP(1'b0), .OHOLDBOT(1'b0), .CI(1'b0), .ACCUMCI(1'b0), .SIGNEXTIN(1'b0),
    .O(mult), .CO(), .ACCUMCO(), .SIGNEXTOUT()
  );
`else
  // Full signed range of A x unsigned B fits exactly in 32 signed bits
  assign mult = $signed({{16{a_q[15]}}, a_q}) * $signed({16'h0, b_q});
`endif

  // Result regs only load on a real product so the bus holds across bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      tag1_q <= '0;
      prod_q <= '0;
    end else begin
      s1_v_q <= s0_v_q;
      if (s0_v_q) begin
        tag1_q <= tag0_q;
        prod_q <= mult;
      end
    end
  end

  assign s0_v_o    = s0_v_q;
  assign res_v_o   = s1_v_q;
  assign res_tag_o = tag1_q;
  assign res_o     = prod_q;
endmodule

// File: rtl/mac_scheduler.sv
// Round-robin share of one multiplier among NUM_REQ valid/ready requesters.
module mac_scheduler
  import mac_scheduler_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = tag_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    iReqValid,
  input  logic [NUM_REQ*16-1:0] iReqA,
  input  logic [NUM_REQ*16-1:0] iReqB,
  output logic [NUM_REQ-1:0]    oReqReady,
  output logic [NUM_REQ-1:0]    oRespValid,
  output logic [31:0]           oResp,
  output logic                  oBusy
);
  logic [ID_W-1:0] ptr_q, ptr_d, gnt_idx, res_tag;
  logic            gnt_found, xfer, s0_v, res_v;
  prod_t           res;

  // First valid requester at or after the pointer, wrapping
  always_comb begin
    int j;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!gnt_found && iReqValid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(j);
      end
    end
  end

  assign xfer = gnt_found & ~reset;

  always_comb begin
    oReqReady = '0;
    if (xfer) oReqReady[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  mac_core #(.ID_W(ID_W)) u_core (
    .clk       (clk),
    .reset     (reset),
    .issue_v_i (xfer),
    .a_i       (iReqA[int'(gnt_idx)*16 +: 16]),
    .b_i       (iReqB[int'(gnt_idx)*16 +: 16]),
    .tag_i     (gnt_idx),
    .s0_v_o    (s0_v),
    .res_v_o   (res_v),
    .res_tag_o (res_tag),
    .res_o     (res)
  );

  // Outputs are forced quiet while reset is held, including the cycle it first asserts
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_resp
    assign oRespValid[r] = res_v & ~reset & (res_tag == ID_W'(r));
  end

  assign oResp = reset ? '0 : res;
  assign oBusy = (s0_v | res_v) & ~reset;
endmodule
